// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_INPUTS = 4;
    localparam int unsigned SEL_W      = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero; zero_c flags the settle window end.
module settle_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through all inputs, samples each after a settle
// window, and presents the assembled word on a valid/ready handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mux_out,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("mux_scan_sequencer: SETTLE_CYCLES must be in 1..255");
    end

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_INPUTS-1:0]   shadow_q, shadow_d;
    logic [NUM_INPUTS-1:0]   word_q, word_d;
    logic                    busy_q, busy_d;
    logic                    word_valid_q, word_valid_d;
    logic                    load;
    logic                    zero_c;

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (CNT_W'(SETTLE_CYCLES - 1)),
        .zero_c     (zero_c)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    sel_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (zero_c) begin
                    shadow_d[sel_q] = mux_out;
                    if (sel_q == SEL_W'(NUM_INPUTS - 1)) begin
                        word_d  = {mux_out, shadow_q[2:0]};
                        sel_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Back-to-back scan starts straight from DONE on acceptance.
                if (word_ready) begin
                    if (start) begin
                        state_d = ST_SCAN;
                        sel_d   = '0;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase

        busy_d       = (state_d == ST_SCAN);
        word_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            shadow_q     <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign address0   = sel_q[0];
    assign address1   = sel_q[1];
    assign busy       = busy_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 2 and 1) behind behavioural
// muxes, checked every cycle against a slot-timing model plus literal checks.
module tb_mux_scan_sequencer;

    localparam int NDUT = 2;

    logic       clk;
    logic       reset;
    logic       start_s   [NDUT];
    logic       ready_s   [NDUT];
    logic [3:0] in_vec    [NDUT];
    logic       mux_w     [NDUT];
    logic       a0_w      [NDUT];
    logic       a1_w      [NDUT];
    logic       busy_w    [NDUT];
    logic [3:0] word_w    [NDUT];
    logic       valid_w   [NDUT];

    int total;
    int bad;

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign mux_w[g] = in_vec[g][{a1_w[g], a0_w[g]}];

        mux_scan_sequencer #(
            .SETTLE_CYCLES ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_s[g]),
            .mux_out    (mux_w[g]),
            .address0   (a0_w[g]),
            .address1   (a1_w[g]),
            .busy       (busy_w[g]),
            .word       (word_w[g]),
            .word_valid (valid_w[g]),
            .word_ready (ready_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a scan is a cycle count since acceptance; slot k ends at (k+1)*S
    // where input k is captured from the input vector as it stood at that edge.
    bit       m_scan [NDUT];
    bit       m_done [NDUT];
    int       m_t    [NDUT];
    bit [3:0] m_bits [NDUT];
    bit [3:0] m_word [NDUT];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NDUT; i++) begin
            if (reset) begin
                m_scan[i] = 0; m_done[i] = 0; m_t[i] = 0;
                m_bits[i] = '0; m_word[i] = '0;
            end else if (m_scan[i]) begin
                m_t[i]++;
                if (m_t[i] % settle_of(i) == 0) begin
                    int k;
                    k = m_t[i] / settle_of(i) - 1;
                    m_bits[i][k] = in_vec[i][k];
                    if (k == 3) begin
                        m_word[i] = m_bits[i];
                        m_scan[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end else if (m_done[i]) begin
                if (ready_s[i]) begin
                    m_done[i] = 0;
                    if (start_s[i]) begin
                        m_scan[i] = 1; m_t[i] = 0;
                    end
                end
            end else if (start_s[i]) begin
                m_scan[i] = 1; m_t[i] = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            for (int i = 0; i < NDUT; i++) begin
                int exp_sel;
                exp_sel = m_scan[i] ? (m_t[i] / settle_of(i)) : 0;
                chk($sformatf("model_sel%0d", i), int'({a1_w[i], a0_w[i]}), exp_sel);
                chk($sformatf("model_busy%0d", i), int'(busy_w[i]), int'(m_scan[i]));
                chk($sformatf("model_valid%0d", i), int'(valid_w[i]), int'(m_done[i]));
                chk($sformatf("model_word%0d", i), int'(word_w[i]), int'(m_word[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, input string name);
        int n;
        n = 0;
        while (valid_w[i] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (valid_w[i] !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start_s[i] = 1'b0;
            ready_s[i] = 1'b0;
            in_vec[i]  = 4'b0000;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset, no start.
        repeat (20) tick();
        chk("idle_word", int'(word_w[0]), 0);
        chk("idle_valid", int'(valid_w[0]), 0);
        chk("idle_busy", int'(busy_w[0]), 0);

        // S=2 basic scan of 1010.
        in_vec[0]  = 4'b1010;
        ready_s[0] = 1'b1;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("basic_sel_e%0d", c), int'({a1_w[0], a0_w[0]}), c / 2);
            chk($sformatf("basic_busy_e%0d", c), int'(busy_w[0]), 1);
            tick();
        end
        chk("basic_valid", int'(valid_w[0]), 1);
        chk("basic_word", int'(word_w[0]), 4'b1010);
        tick();
        chk("basic_idle_valid", int'(valid_w[0]), 0);
        chk("basic_idle_busy", int'(busy_w[0]), 0);

        // Backpressure: word held while inputs toggle and start pulses.
        ready_s[0] = 1'b0;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        wait_valid(0, "bp");
        for (int c = 0; c < 5; c++) begin
            in_vec[0]  = ~in_vec[0];
            start_s[0] = (c % 2 == 0);
            tick();
            chk($sformatf("bp_word_c%0d", c), int'(word_w[0]), 4'b1010);
            chk($sformatf("bp_valid_c%0d", c), int'(valid_w[0]), 1);
            chk($sformatf("bp_busy_c%0d", c), int'(busy_w[0]), 0);
        end
        start_s[0] = 1'b0;
        in_vec[0]  = 4'b1010;
        ready_s[0] = 1'b1;
        tick();
        chk("bp_accept_valid", int'(valid_w[0]), 0);
        chk("bp_accept_busy", int'(busy_w[0]), 0);

        // Back-to-back: accept 1010 and restart at the same edge for 0101.
        ready_s[0] = 1'b0;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        wait_valid(0, "b2b_first");
        chk("b2b_first_word", int'(word_w[0]), 4'b1010);
        in_vec[0]  = 4'b0101;
        ready_s[0] = 1'b1;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        chk("b2b_busy", int'(busy_w[0]), 1);
        chk("b2b_sel", int'({a1_w[0], a0_w[0]}), 0);
        chk("b2b_valid_low", int'(valid_w[0]), 0);
        repeat (7) tick();
        chk("b2b_not_early", int'(valid_w[0]), 0);
        tick();
        chk("b2b_valid", int'(valid_w[0]), 1);
        chk("b2b_word", int'(word_w[0]), 4'b0101);
        tick();

        // Asynchronous reset while select = 2.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        begin
            int n;
            n = 0;
            while ({a1_w[0], a0_w[0]} != 2'd2 && n < 20) begin
                tick();
                n++;
            end
            if ({a1_w[0], a0_w[0]} != 2'd2) chk("rst_wait_sel2_timeout", 0, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rst_sel", int'({a1_w[0], a0_w[0]}), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_valid", int'(valid_w[0]), 0);
        chk("rst_word", int'(word_w[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) tick();
        chk("rst_no_valid", int'(valid_w[0]), 0);
        chk("rst_no_busy", int'(busy_w[0]), 0);

        // S=1: in1 rises one cycle before its sample edge.
        in_vec[1]  = 4'b1001;
        ready_s[1] = 1'b1;
        start_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0;
        tick();
        in_vec[1][1] = 1'b1;
        tick();
        tick();
        chk("s1_not_early", int'(valid_w[1]), 0);
        tick();
        chk("s1_valid", int'(valid_w[1]), 1);
        chk("s1_word", int'(word_w[1]), 4'b1011);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
